// File: rtl/uart_tx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer_if
// Brief    : Producer-side write bus and uart_tx-side pacing handshake for
//            uart_tx_buffer. Modport slave is the buffer's own view.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_buffer_if #(
    parameter int ADDR_W = 4
) ();
    logic [7:0]      din;
    logic            din_vld;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] usedw;
    logic            overflow;
    logic            tx_busy;
    logic [7:0]      tx_dout;
    logic            tx_dout_vld;

    modport slave (
        input  din, din_vld, tx_busy,
        output full, empty, usedw, overflow, tx_dout, tx_dout_vld
    );

    modport master (
        output din, din_vld, tx_busy,
        input  full, empty, usedw, overflow, tx_dout, tx_dout_vld
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Brief    : Byte FIFO feeding uart_tx one strobe per frame, paced by tx_busy.
//            Define UART_TXBUF_DROP_CNT_EN to add the drop_cnt/drop_clr counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffer #(
    parameter int ADDR_W  = 4,
    parameter int BUSY_TO = 16,
    parameter int GAP_CYC = 2
) (
    input  wire             clk,
    input  wire             rst,
`ifdef UART_TXBUF_DROP_CNT_EN
    input  wire             drop_clr,
    output logic [15:0]     drop_cnt,
`endif
    uart_tx_buffer_if.slave bus
);

    localparam int              c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_FULL_CNT  = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [7:0]      c_BUSY_LAST = 8'(BUSY_TO - 1);
    localparam logic [7:0]      c_GAP_LAST  = 8'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT_HI = 2'd1;
    localparam logic [1:0] c_ST_WAIT_LO = 2'd2;
    localparam logic [1:0] c_ST_GAP     = 2'd3;

    logic [7:0]        r_mem [0:c_DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [7:0]        r_tx_dout;
    logic              r_tx_dout_vld;
    logic [1:0]        r_state;
    logic [7:0]        r_timer;

    logic              w_wr;
    logic              w_pop;
    logic [ADDR_W:0]   w_count_nxt;

    // Both decisions use registered flags, so a pop never makes room for a
    // write in the same cycle.
    assign w_wr        = bus.din_vld & ~r_full;
    assign w_pop       = (r_state == c_ST_IDLE) & ~r_empty & ~bus.tx_busy;
    assign w_count_nxt = r_count + (ADDR_W + 1)'(w_wr) - (ADDR_W + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_overflow    <= 1'b0;
            r_tx_dout     <= 8'h00;
            r_tx_dout_vld <= 1'b0;
            r_state       <= c_ST_IDLE;
            r_timer       <= 8'd0;
        end else begin
            r_overflow    <= bus.din_vld & r_full;
            r_tx_dout_vld <= 1'b0;
            r_count       <= w_count_nxt;
            r_full        <= (w_count_nxt == c_FULL_CNT);
            r_empty       <= (w_count_nxt == '0);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_dout     <= r_mem[r_rd_ptr];
                        r_tx_dout_vld <= 1'b1;
                        r_rd_ptr      <= r_rd_ptr + 1'b1;
                        r_timer       <= 8'd0;
                        r_state       <= c_ST_WAIT_HI;
                    end
                end
                c_ST_WAIT_HI: begin
                    // A uart_tx that never raises busy must not stall the queue.
                    if (bus.tx_busy) begin
                        r_state <= c_ST_WAIT_LO;
                    end else if (r_timer == c_BUSY_LAST) begin
                        r_timer <= 8'd0;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                c_ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        r_timer <= 8'd0;
                        r_state <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    if (r_timer == c_GAP_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.usedw       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.tx_dout     = r_tx_dout;
    assign bus.tx_dout_vld = r_tx_dout_vld;

`ifdef UART_TXBUF_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (drop_clr) begin
            r_drop_cnt <= 16'h0000;
        end else if (r_overflow && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Brief    : Directed and randomized bench for uart_tx_buffer with a queue
//            scoreboard and a simple uart_tx busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int ADDR_W  = 4;
    localparam int BUSY_TO = 16;
    localparam int GAP_CYC = 2;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    uart_tx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef UART_TXBUF_DROP_CNT_EN
    logic        drop_clr;
    logic [15:0] drop_cnt;
`endif

    uart_tx_buffer #(
        .ADDR_W  (ADDR_W),
        .BUSY_TO (BUSY_TO),
        .GAP_CYC (GAP_CYC)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
`ifdef UART_TXBUF_DROP_CNT_EN
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the cycle after a strobe, lasts busy_len.
    logic model_en;
    logic busy_force;
    int   busy_len;
    int   busy_cnt;

    always @(posedge clk) begin
        if (!model_en)                 busy_cnt <= 0;
        else if (bus.tx_dout_vld)      busy_cnt <= busy_len;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end

    assign bus.tx_busy = model_en ? (busy_cnt != 0) : busy_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: FIFO occupancy and byte order from the write/pop rules.
    logic       mon_en;
    logic [7:0] exp_q [$];
    int         strb_cyc [$];
    int         cyc;
    int         n_strobe;
    int         n_ovf;
    logic       exp_ovf;
    logic       prev_vld;

    initial begin
        cyc = 0; n_strobe = 0; n_ovf = 0; exp_ovf = 1'b0; prev_vld = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.tx_dout_vld) begin
                strb_cyc.push_back(cyc);
                n_strobe++;
                check("strobe_single_cycle", 32'(prev_vld), 32'd0);
                if (exp_q.size() == 0) check("strobe_unexpected", 32'd1, 32'(exp_q.size()));
                else                   check("tx_dout_order", 32'(bus.tx_dout), 32'(exp_q.pop_front()));
            end
            prev_vld = bus.tx_dout_vld;
            check("overflow", 32'(bus.overflow), 32'(exp_ovf));
            if (bus.overflow) n_ovf++;
            check("usedw", 32'(bus.usedw), 32'(exp_q.size()));
            check("full",  32'(bus.full),  32'(exp_q.size() == DEPTH));
            check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
            exp_ovf = 1'b0;
            if (rst) begin
                exp_q.delete();
            end else if (bus.din_vld) begin
                if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
                else                       exp_q.push_back(bus.din);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        bus.din     = b;
        bus.din_vld = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        bus.din_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobes(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (n_strobe < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(n_strobe >= target), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"},  32'(bus.full), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_usedw"}, 32'(bus.usedw), 32'd0);
        check({tag, "_ovf"},   32'(bus.overflow), 32'd0);
        check({tag, "_dout"},  32'(bus.tx_dout), 32'h00);
        check({tag, "_vld"},   32'(bus.tx_dout_vld), 32'd0);
    endtask

    initial begin
        int s0;
        int ovf0;
        errors = 0; checks = 0;
        mon_en = 1'b0; model_en = 1'b0; busy_force = 1'b0; busy_len = 100;
        rst = 1'b1; bus.din = 8'h00; bus.din_vld = 1'b0;
`ifdef UART_TXBUF_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");
`ifdef UART_TXBUF_DROP_CNT_EN
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        mon_en = 1'b1;

        // Single byte: empty clears next cycle, strobe 2 cycles after din_vld.
        write_byte(8'h55);
        @(negedge clk); bus.din_vld = 1'b0;
        check("t1_empty", 32'(bus.empty), 32'd0);
        check("t1_vld_early", 32'(bus.tx_dout_vld), 32'd0);
        @(negedge clk);
        check("t1_vld", 32'(bus.tx_dout_vld), 32'd1);
        check("t1_dout", 32'(bus.tx_dout), 32'h55);
        @(negedge clk);
        check("t1_vld_drop", 32'(bus.tx_dout_vld), 32'd0);
        repeat (30) @(negedge clk);

        // Burst of five against the busy model.
        do_reset();
        model_en = 1'b1; busy_len = 100;
        strb_cyc.delete();
        s0 = n_strobe;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        idle_cycles(1);
        wait_strobes("t2_strobes", s0 + 5, 1000);
        if (strb_cyc.size() >= 5) begin
            for (int i = 1; i < 5; i++)
                check("t2_period", 32'(strb_cyc[i] - strb_cyc[i-1]), 32'(3 + busy_len + GAP_CYC));
        end
        repeat (110) @(negedge clk);

        // Seventeen writes while uart_tx is held busy.
        do_reset();
        model_en = 1'b0; busy_force = 1'b1;
        ovf0 = n_ovf;
        for (int i = 0; i < 17; i++) begin
            write_byte(8'($urandom));
            if (i == 16) begin
                check("t3_full", 32'(bus.full), 32'd1);
                check("t3_usedw16", 32'(bus.usedw), 32'd16);
            end
        end
        @(negedge clk); bus.din_vld = 1'b0;
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        @(negedge clk);
        check("t3_ovf_once", 32'(n_ovf - ovf0), 32'd1);
        check("t3_usedw", 32'(bus.usedw), 32'd16);
`ifdef UART_TXBUF_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        drop_clr = 1'b1;
        @(negedge clk); drop_clr = 1'b0;
        check("t3_drop_clr", 32'(drop_cnt), 32'd0);
`endif
        s0 = n_strobe;
        busy_len = 5; busy_force = 1'b0; model_en = 1'b1;
        wait_strobes("t3_drain", s0 + 16, 1000);
        repeat (20) @(negedge clk);

        // uart_tx never asserts busy: WAIT_HI timeout paces the strobes.
        do_reset();
        model_en = 1'b0; busy_force = 1'b0;
        strb_cyc.delete();
        s0 = n_strobe;
        write_byte(8'hA5);
        write_byte(8'h5A);
        idle_cycles(1);
        wait_strobes("t4_strobes", s0 + 2, 200);
        if (strb_cyc.size() >= 2)
            check("t4_timeout_gap", 32'(strb_cyc[1] - strb_cyc[0]), 32'(BUSY_TO + GAP_CYC + 1));
        repeat (25) @(negedge clk);

        // Random traffic across the full boundary while draining.
        do_reset();
        model_en = 1'b1; busy_len = int'($urandom_range(4, 9));
        for (int i = 0; i < 20; i++) write_byte(8'($urandom));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.din     = 8'($urandom);
            bus.din_vld = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); bus.din_vld = 1'b0;
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        repeat (30) @(negedge clk);

        // Reset with three bytes queued and the FSM waiting for busy to fall.
        do_reset();
        model_en = 1'b1; busy_len = 100;
        for (int i = 0; i < 4; i++) write_byte(8'hE0 + 8'(i));
        idle_cycles(20);
        check("t6_queued", 32'(bus.usedw), 32'd3);
        check("t6_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset_values("t6_reset");
        s0 = n_strobe;
        repeat (150) @(negedge clk);
        check("t6_no_strobe", 32'(n_strobe), 32'(s0));
        write_byte(8'hC3);
        idle_cycles(1);
        wait_strobes("t6_after_reset", s0 + 1, 300);
        check("t6_last_dout", 32'(bus.tx_dout), 32'hC3);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
